// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for clk_divider_prog.
// CLKDIV_SYNC_CLEAR_EN adds the sync_clr phase-align input.
interface clk_divider_prog_if #(
   parameter int unsigned CNT_WIDTH = 28
);
   logic                 enable;
   logic [1:0]           mode_sel;
   logic                 div_load;
   logic [CNT_WIDTH-1:0] div_value;
`ifdef CLKDIV_SYNC_CLEAR_EN
   logic                 sync_clr;
`endif
   logic                 clock_out;
   logic                 tick;
   logic                 div_busy;
   logic [CNT_WIDTH-1:0] div_active;

   modport master (
`ifdef CLKDIV_SYNC_CLEAR_EN
      output sync_clr,
`endif
      output enable, mode_sel, div_load, div_value,
      input  clock_out, tick, div_busy, div_active
   );

   modport slave (
`ifdef CLKDIV_SYNC_CLEAR_EN
      input  sync_clr,
`endif
      input  enable, mode_sel, div_load, div_value,
      output clock_out, tick, div_busy, div_active
   );
endinterface

// File: rtl/clk_divider_prog.sv
// Run-time programmable clock divider; ratio changes are applied only at a period wrap.
// Optional macro CLKDIV_SYNC_CLEAR_EN enables the sync_clr forced-wrap input.
module clk_divider_prog #(
   parameter int unsigned CNT_WIDTH    = 28,
   parameter int unsigned DIV_NORMAL   = 50000000,
   parameter int unsigned DIV_SLOW     = 100000000,
   parameter int unsigned DIV_FAST     = 5000000,
   parameter int unsigned DIV_PROG_RST = 50000000
) (
   input logic              clock_in,
   input logic              reset_n,
   clk_divider_prog_if.slave bus
);

   localparam longint unsigned MaxDiv = 64'd1 << CNT_WIDTH;

   if (DIV_NORMAL < 2 || DIV_NORMAL >= MaxDiv ||
       DIV_SLOW < 2 || DIV_SLOW >= MaxDiv ||
       DIV_FAST < 2 || DIV_FAST >= MaxDiv ||
       DIV_PROG_RST < 2 || DIV_PROG_RST >= MaxDiv) begin : g_param_err
      $error("clk_divider_prog: every DIV_* must be >= 2 and < 2**CNT_WIDTH");
   end

   localparam logic [CNT_WIDTH-1:0] DivNormal  = CNT_WIDTH'(DIV_NORMAL);
   localparam logic [CNT_WIDTH-1:0] DivSlow    = CNT_WIDTH'(DIV_SLOW);
   localparam logic [CNT_WIDTH-1:0] DivFast    = CNT_WIDTH'(DIV_FAST);
   localparam logic [CNT_WIDTH-1:0] DivProgRst = CNT_WIDTH'(DIV_PROG_RST);
   localparam logic [CNT_WIDTH-1:0] DivMin     = CNT_WIDTH'(2);
   localparam logic [CNT_WIDTH-1:0] One        = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] active_q, active_d;
   logic [CNT_WIDTH-1:0] prog_q, prog_d;
   logic                 clock_out_q, clock_out_d;
   logic                 tick_q, tick_d;
   logic [CNT_WIDTH-1:0] target;
   logic                 wrap;
   logic                 force_wrap;

`ifdef CLKDIV_SYNC_CLEAR_EN
   assign force_wrap = bus.sync_clr;
`else
   assign force_wrap = 1'b0;
`endif

   always_comb begin
      target = DivNormal;
      unique case (bus.mode_sel)
         2'd0:    target = DivNormal;
         2'd1:    target = DivSlow;
         2'd2:    target = DivFast;
         2'd3:    target = prog_q;
         default: target = DivNormal;
      endcase
   end

   // Loads of 0 or 1 would stall the counter, so clamp to the minimum ratio.
   always_comb begin
      prog_d = prog_q;
      if (bus.div_load) begin
         prog_d = (bus.div_value < DivMin) ? DivMin : bus.div_value;
      end
   end

   assign wrap = (cnt_q == active_q - One);

   always_comb begin
      cnt_d       = cnt_q;
      active_d    = active_q;
      clock_out_d = clock_out_q;
      tick_d      = 1'b0;
      if (force_wrap || (bus.enable && wrap)) begin
         cnt_d    = '0;
         active_d = target;
      end else if (bus.enable) begin
         cnt_d = cnt_q + One;
      end
      // Phase is judged against the divisor of the period that starts at this edge.
      if (force_wrap || bus.enable) begin
         clock_out_d = (cnt_d < (active_d >> 1));
         tick_d      = (cnt_d == '0);
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= DivNormal - One;
         active_q    <= DivNormal;
         prog_q      <= DivProgRst;
         clock_out_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         prog_q      <= prog_d;
         clock_out_q <= clock_out_d;
         tick_q      <= tick_d;
      end
   end

   assign bus.clock_out  = clock_out_q;
   assign bus.tick       = tick_q;
   assign bus.div_busy   = (target != active_q);
   assign bus.div_active = active_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: small divisors, table of per-edge expectations
// plus hand-written reset, pause/load and sync-clear sequences.
module tb_clk_divider_prog;

   localparam int unsigned W = 8;

   logic clk;
   logic reset_n;

   clk_divider_prog_if #(.CNT_WIDTH(W)) bus ();

   clk_divider_prog #(
      .CNT_WIDTH   (W),
      .DIV_NORMAL  (4),
      .DIV_SLOW    (10),
      .DIV_FAST    (6),
      .DIV_PROG_RST(5)
   ) dut (
      .clock_in(clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic [1:0]   mode;
      logic         load;
      logic [W-1:0] val;
      int           n;
      logic         co;
      logic         tk;
      logic         busy;
      logic [W-1:0] act;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic load,
                               input logic [W-1:0] val, input int n, input logic co,
                               input logic tk, input logic busy, input logic [W-1:0] act);
      vec_t v;
      v.en = en; v.mode = mode; v.load = load; v.val = val; v.n = n;
      v.co = co; v.tk = tk; v.busy = busy; v.act = act;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic co, input logic tk,
                             input logic busy, input logic [W-1:0] act);
      check({name, ".clock_out"}, 32'(bus.clock_out), 32'(co));
      check({name, ".tick"}, 32'(bus.tick), 32'(tk));
      check({name, ".div_busy"}, 32'(bus.div_busy), 32'(busy));
      check({name, ".div_active"}, 32'(bus.div_active), 32'(act));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Test plan 1: mode 0, D=4
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 4));
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 4));
      vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 4));
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 4));
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 4));
      // Test plan 2: switch to slow at cnt=1
      vecs.push_back(mk(1, 1, 0, 0, 2, 0, 0, 1, 4));
      vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 10));
      vecs.push_back(mk(1, 1, 0, 0, 4, 1, 0, 0, 10));
      vecs.push_back(mk(1, 1, 0, 0, 5, 0, 0, 0, 10));
      vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 10));
      // Test plan 3: programmed, load 0 clamps to 2, then load 7
      vecs.push_back(mk(1, 3, 1, 0, 1, 1, 0, 1, 10));
      vecs.push_back(mk(1, 3, 0, 0, 3, 1, 0, 1, 10));
      vecs.push_back(mk(1, 3, 0, 0, 5, 0, 0, 1, 10));
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 0, 2));
      vecs.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0, 2));
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 0, 2));
      vecs.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0, 2));
      vecs.push_back(mk(1, 3, 1, 7, 1, 1, 1, 1, 2));
      vecs.push_back(mk(1, 3, 0, 0, 1, 0, 0, 1, 2));
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 0, 7));
      vecs.push_back(mk(1, 3, 0, 0, 2, 1, 0, 0, 7));
      vecs.push_back(mk(1, 3, 0, 0, 4, 0, 0, 0, 7));
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 0, 7));
      // Test plan 4: pause 6 cycles in high phase
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 7));
      vecs.push_back(mk(0, 3, 0, 0, 6, 1, 0, 0, 7));
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 7));
      vecs.push_back(mk(1, 3, 0, 0, 4, 0, 0, 0, 7));
      vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 0, 7));

      bus.enable    = 1'b0;
      bus.mode_sel  = 2'd0;
      bus.div_load  = 1'b0;
      bus.div_value = '0;
`ifdef CLKDIV_SYNC_CLEAR_EN
      bus.sync_clr  = 1'b0;
`endif
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b0, 1'b0, W'(4));
      reset_n    = 1'b1;
      bus.enable = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.enable    = vecs[i].en;
         bus.mode_sel  = vecs[i].mode;
         bus.div_load  = vecs[i].load;
         bus.div_value = vecs[i].val;
         for (int k = 0; k < vecs[i].n; k++) begin
            step();
            check_outs($sformatf("vec%0d.%0d", i, k), vecs[i].co, vecs[i].tk,
                       vecs[i].busy, vecs[i].act);
         end
      end

      // Test plan 5: asynchronous reset between edges while clock_out/tick are high
      bus.enable   = 1'b1;
      bus.div_load = 1'b0;
      bus.mode_sel = 2'd0;
      #3;
      reset_n = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 1'b0, 1'b0, W'(4));
      step();
      reset_n = 1'b1;
      step();
      check_outs("rst_first", 1'b1, 1'b1, 1'b0, W'(4));
      step();
      check_outs("rst_second", 1'b1, 1'b0, 1'b0, W'(4));

      // Pause with register writes; a target that returns to div_active clears busy
      bus.mode_sel = 2'd3;
      #1;
      check("busy_prog_rst", 32'(bus.div_busy), 32'd1);
      bus.enable    = 1'b0;
      bus.div_load  = 1'b1;
      bus.div_value = W'(1);
      step();
      check_outs("pause_load1", 1'b1, 1'b0, 1'b1, W'(4));
      bus.div_value = W'(9);
      step();
      bus.div_value = W'(4);
      step();
      bus.div_load = 1'b0;
      #1;
      check_outs("pause_last_load", 1'b1, 1'b0, 1'b0, W'(4));
      bus.mode_sel = 2'd0;
      bus.enable   = 1'b1;
      step();
      check_outs("resume", 1'b0, 1'b0, 1'b0, W'(4));

`ifdef CLKDIV_SYNC_CLEAR_EN
      // Test plan 6: sync_clr at cnt=2 while paused restarts a full period
      bus.enable   = 1'b0;
      bus.sync_clr = 1'b1;
      step();
      check_outs("sclr", 1'b1, 1'b1, 1'b0, W'(4));
      bus.sync_clr = 1'b0;
      bus.enable   = 1'b1;
      step();
      check_outs("sclr_c1", 1'b1, 1'b0, 1'b0, W'(4));
      step();
      check_outs("sclr_c2", 1'b0, 1'b0, 1'b0, W'(4));
      step();
      check_outs("sclr_c3", 1'b0, 1'b0, 1'b0, W'(4));
      step();
      check_outs("sclr_wrap", 1'b1, 1'b1, 1'b0, W'(4));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
